// File: rtl/qa_write_burst_pkg.sv
// Shared types and helpers for the QA driver write-burst sequencer:
// CCI line types, sequencer state, packet-size selection and counter width.
package qa_write_burst_pkg;

    localparam int CL_ADDR_W             = 42;
    localparam int CL_DATA_W             = 512;
    localparam int MAX_OUTSTANDING_LIMIT = 1024;

    typedef logic [CL_ADDR_W-1:0] t_cci_clAddr;
    typedef logic [CL_DATA_W-1:0] t_cci_clData;

    // Encoding doubles as (lines - 1), which the sequencer uses as the last beat index.
    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_cci_clLen;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } t_wrburst_state;

    function automatic int outstanding_w(input int max_outstanding);
        return $clog2(max_outstanding) + 1;
    endfunction

    localparam int OUTSTANDING_W_MAX = outstanding_w(MAX_OUTSTANDING_LIMIT);

    function automatic t_cci_clLen pick_pkt_len(input logic [1:0]  addr_low,
                                                input logic [31:0] remaining,
                                                input int          max_pkt);
        if (max_pkt >= 4 && addr_low == 2'b00 && remaining >= 32'd4)
            return eCL_LEN_4;
        else if (max_pkt >= 2 && addr_low[0] == 1'b0 && remaining >= 32'd2)
            return eCL_LEN_2;
        else
            return eCL_LEN_1;
    endfunction

endpackage

// File: rtl/qa_write_ack_counter.sv
// Un-acked line counter: +1 per issued beat, -ack per cycle, floored at 0.
// can_issue is derived from the registered count only, so it never loops back through issue.
module qa_write_ack_counter
    import qa_write_burst_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 256
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             issue,
    input  logic [1:0]                       ack,
    output logic [$clog2(MAX_OUTSTANDING):0] count,
    output logic                             can_issue
);

    localparam int                CNT_W   = outstanding_w(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W:0] sum;
    logic [CNT_W:0] ack_ext;

    always_comb begin
        sum       = (CNT_W+1)'(count) + (CNT_W+1)'(issue);
        ack_ext   = (CNT_W+1)'(ack);
        can_issue = (count < MAX_CNT);
    end

    // Late acks from a burst abandoned by reset must not underflow the count.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (ack_ext > sum)
            count <= '0;
        else
            count <= CNT_W'(sum - ack_ext);
    end

endmodule

// File: rtl/qa_write_burst_sequencer.sv
// Splits write bursts into aligned 4/2/1-line CCI packets and issues them beat by beat.
// Optional QA_WR_BURST_STATS_EN adds saturating beat/packet/stall counters.
module qa_write_burst_sequencer
    import qa_write_burst_pkg::*;
#(
    parameter int LINES_W         = 16,
    parameter int MAX_PKT_LINES   = 4,
    parameter int MAX_OUTSTANDING = 256
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_rdy,
    input  t_cci_clAddr                      req_addr,
    input  logic [LINES_W-1:0]               req_lines,
    input  logic                             req_cached,
    input  logic                             req_check_order,
    input  t_cci_clData                      wr_data,
    input  logic                             wr_data_valid,
    output logic                             wr_data_rdy,
    output t_cci_clAddr                      mem_write_addr,
    output t_cci_clData                      mem_write_data,
    output t_cci_clLen                       mem_write_req_num_lines,
    output logic                             mem_write_req_sop,
    output logic                             mem_write_req_cached,
    output logic                             mem_write_req_check_order,
    output logic                             mem_write_enable,
    input  logic                             mem_write_rdy,
    input  logic [1:0]                       mem_write_ack,
    output logic                             burst_done,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                             idle
`ifdef QA_WR_BURST_STATS_EN
    ,
    output logic [31:0]                      stat_beats,
    output logic [31:0]                      stat_pkts4,
    output logic [31:0]                      stat_stall_cycles
`endif
);

    t_wrburst_state     state;
    t_cci_clAddr        addr_q;
    logic [LINES_W-1:0] rem_q;
    logic [1:0]         beat_idx;
    t_cci_clLen         pkt_len_q;
    t_cci_clLen         sop_len;
    t_cci_clLen         cur_len;
    logic               cached_q;
    logic               order_q;
    logic               can_issue;
    logic               active;
    logic               accept;
    logic               last_beat;
    logic               last_in_pkt;

    // The packet size is chosen at beat 0 and frozen in pkt_len_q for the remaining beats.
    always_comb begin
        active                    = (state == ACTIVE) && !reset;
        req_rdy                   = (state == IDLE) && !reset;
        accept                    = req_valid && req_rdy;
        sop_len                   = pick_pkt_len(addr_q[1:0], 32'(rem_q), MAX_PKT_LINES);
        cur_len                   = (beat_idx == 2'd0) ? sop_len : pkt_len_q;
        last_beat                 = (rem_q == LINES_W'(1));
        last_in_pkt               = (beat_idx == 2'(cur_len));
        mem_write_enable          = active && mem_write_rdy && wr_data_valid && can_issue;
        wr_data_rdy               = mem_write_enable;
        mem_write_addr            = addr_q;
        mem_write_data            = mem_write_enable ? wr_data : '0;
        mem_write_req_num_lines   = active ? cur_len : eCL_LEN_1;
        mem_write_req_sop         = active && (beat_idx == 2'd0);
        mem_write_req_cached      = cached_q;
        mem_write_req_check_order = order_q;
        idle                      = (state == IDLE) && (outstanding == '0) && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            beat_idx   <= 2'd0;
            pkt_len_q  <= eCL_LEN_1;
            cached_q   <= 1'b0;
            order_q    <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= (accept && (req_lines == '0)) || (mem_write_enable && last_beat);
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q   <= req_addr;
                        rem_q    <= req_lines;
                        cached_q <= req_cached;
                        order_q  <= req_check_order;
                        beat_idx <= 2'd0;
                        if (req_lines != '0)
                            state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (mem_write_enable) begin
                        addr_q <= addr_q + CL_ADDR_W'(1);
                        rem_q  <= rem_q - LINES_W'(1);
                        if (beat_idx == 2'd0)
                            pkt_len_q <= sop_len;
                        beat_idx <= last_in_pkt ? 2'd0 : beat_idx + 2'd1;
                        if (last_beat)
                            state <= IDLE;
                    end
                end
            endcase
        end
    end

    qa_write_ack_counter #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_ack_counter (
        .clk       (clk),
        .reset     (reset),
        .issue     (mem_write_enable),
        .ack       (mem_write_ack),
        .count     (outstanding),
        .can_issue (can_issue)
    );

`ifdef QA_WR_BURST_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_beats        <= '0;
            stat_pkts4        <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (mem_write_enable)
                stat_beats <= sat_inc(stat_beats);
            if (mem_write_enable && mem_write_req_sop && (cur_len == eCL_LEN_4))
                stat_pkts4 <= sat_inc(stat_pkts4);
            if (active && !mem_write_enable)
                stat_stall_cycles <= sat_inc(stat_stall_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_qa_write_burst_sequencer.sv
// Directed bench for qa_write_burst_sequencer built with MAX_OUTSTANDING=4.
// Inputs change and outputs are sampled just after the falling edge.
module tb_qa_write_burst_sequencer;
    import qa_write_burst_pkg::*;

    localparam int LINES_W = 16;
    localparam int MAX_OUT = 4;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        req_valid;
    logic                        req_rdy;
    t_cci_clAddr                 req_addr;
    logic [LINES_W-1:0]          req_lines;
    logic                        req_cached;
    logic                        req_check_order;
    t_cci_clData                 wr_data;
    logic                        wr_data_valid;
    logic                        wr_data_rdy;
    t_cci_clAddr                 mem_write_addr;
    t_cci_clData                 mem_write_data;
    t_cci_clLen                  mem_write_req_num_lines;
    logic                        mem_write_req_sop;
    logic                        mem_write_req_cached;
    logic                        mem_write_req_check_order;
    logic                        mem_write_enable;
    logic                        mem_write_rdy;
    logic [1:0]                  mem_write_ack;
    logic                        burst_done;
    logic [$clog2(MAX_OUT):0]    outstanding;
    logic                        idle;

    logic       auto_ack;
    logic       ack_pipe;
    logic [1:0] ack_man;

    int checks = 0;
    int errors = 0;

    qa_write_burst_sequencer #(
        .LINES_W        (LINES_W),
        .MAX_PKT_LINES  (4),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .req_valid                (req_valid),
        .req_rdy                  (req_rdy),
        .req_addr                 (req_addr),
        .req_lines                (req_lines),
        .req_cached               (req_cached),
        .req_check_order          (req_check_order),
        .wr_data                  (wr_data),
        .wr_data_valid            (wr_data_valid),
        .wr_data_rdy              (wr_data_rdy),
        .mem_write_addr           (mem_write_addr),
        .mem_write_data           (mem_write_data),
        .mem_write_req_num_lines  (mem_write_req_num_lines),
        .mem_write_req_sop        (mem_write_req_sop),
        .mem_write_req_cached     (mem_write_req_cached),
        .mem_write_req_check_order(mem_write_req_check_order),
        .mem_write_enable         (mem_write_enable),
        .mem_write_rdy            (mem_write_rdy),
        .mem_write_ack            (mem_write_ack),
        .burst_done               (burst_done),
        .outstanding              (outstanding),
        .idle                     (idle)
    );

    always #5 clk = ~clk;

    // Auto mode acks every beat exactly one cycle after it issues.
    always @(posedge clk) ack_pipe <= auto_ack && mem_write_enable;
    assign mem_write_ack = auto_ack ? {1'b0, ack_pipe} : ack_man;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_req(input logic [41:0] addr, input int lines, input logic cached,
                             input logic order);
        @(negedge clk);
        req_valid       = 1'b1;
        req_addr        = addr;
        req_lines       = LINES_W'(lines);
        req_cached      = cached;
        req_check_order = order;
        #1;
        checks++;
        if (req_rdy !== 1'b1 || mem_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL accept_cycle: req_rdy=%0b enable=%0b expected 1/0", req_rdy, mem_write_enable);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_lines = '0; req_cached = 1'b0;
        req_check_order = 1'b0; wr_data = '0; wr_data_valid = 1'b0; mem_write_rdy = 1'b0;
        auto_ack = 1'b0; ack_man = 2'd0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (req_rdy !== 1'b0 || idle !== 1'b0) begin
            errors++; $display("FAIL reset_rdy_idle: req_rdy=%0b idle=%0b expected 0/0", req_rdy, idle);
        end
        checks++;
        if (mem_write_enable !== 1'b0 || wr_data_rdy !== 1'b0 || burst_done !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: en=%0b wr_rdy=%0b done=%0b expected 0", mem_write_enable, wr_data_rdy, burst_done);
        end
        checks++;
        if (outstanding !== '0 || mem_write_addr !== '0 || mem_write_data !== '0) begin
            errors++; $display("FAIL reset_regs: out=%0d addr=%h data_nz=%0b expected 0", outstanding, mem_write_addr, |mem_write_data);
        end
        checks++;
        if (mem_write_req_sop !== 1'b0 || mem_write_req_num_lines !== eCL_LEN_1 ||
            mem_write_req_cached !== 1'b0 || mem_write_req_check_order !== 1'b0) begin
            errors++; $display("FAIL reset_fields: sop=%0b len=%0d cached=%0b order=%0b expected 0", mem_write_req_sop, mem_write_req_num_lines, mem_write_req_cached, mem_write_req_check_order);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (req_rdy !== 1'b1 || idle !== 1'b1) begin
            errors++; $display("FAIL post_reset: req_rdy=%0b idle=%0b expected 1/1", req_rdy, idle);
        end
    endtask

    task automatic test_aligned_burst();
        bit         exp_sop [7] = '{1, 0, 0, 0, 1, 0, 1};
        t_cci_clLen exp_len [7] = '{eCL_LEN_4, eCL_LEN_4, eCL_LEN_4, eCL_LEN_4, eCL_LEN_2, eCL_LEN_2, eCL_LEN_1};
        wr_data_valid = 1'b1; mem_write_rdy = 1'b1; auto_ack = 1'b1;
        start_req(42'h100, 7, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            wr_data   = {16{32'hA5A5_0000 + 32'(i)}};
            #1;
            checks++;
            if (mem_write_enable !== 1'b1 || wr_data_rdy !== 1'b1 || mem_write_data !== wr_data) begin
                errors++; $display("FAIL aligned_issue[%0d]: en=%0b wr_rdy=%0b data_ok=%0b expected 1/1/1", i, mem_write_enable, wr_data_rdy, mem_write_data === wr_data);
            end
            checks++;
            if (mem_write_addr !== 42'h100 + 42'(i) || mem_write_req_sop !== exp_sop[i] ||
                mem_write_req_num_lines !== exp_len[i]) begin
                errors++; $display("FAIL aligned_beat[%0d]: addr=%h sop=%0b len=%0d expected %h/%0b/%0d", i, mem_write_addr, mem_write_req_sop, mem_write_req_num_lines, 42'h100 + 42'(i), exp_sop[i], exp_len[i]);
            end
            checks++;
            if (mem_write_req_cached !== 1'b1 || mem_write_req_check_order !== 1'b0 ||
                outstanding !== ((i == 0) ? 3'd0 : 3'd1) || burst_done !== 1'b0) begin
                errors++; $display("FAIL aligned_state[%0d]: cached=%0b order=%0b out=%0d done=%0b", i, mem_write_req_cached, mem_write_req_check_order, outstanding, burst_done);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem_write_enable !== 1'b0 || burst_done !== 1'b1 || req_rdy !== 1'b1 || outstanding !== 3'd1) begin
            errors++; $display("FAIL aligned_done: en=%0b done=%0b rdy=%0b out=%0d expected 0/1/1/1", mem_write_enable, burst_done, req_rdy, outstanding);
        end
        @(negedge clk);
        auto_ack = 1'b0;
        #1;
        checks++;
        if (burst_done !== 1'b0 || outstanding !== 3'd0 || idle !== 1'b1) begin
            errors++; $display("FAIL aligned_drain: done=%0b out=%0d idle=%0b expected 0/0/1", burst_done, outstanding, idle);
        end
    endtask

    task automatic test_unaligned_burst();
        bit         exp_sop [6] = '{1, 1, 0, 0, 0, 1};
        t_cci_clLen exp_len [6] = '{eCL_LEN_1, eCL_LEN_4, eCL_LEN_4, eCL_LEN_4, eCL_LEN_4, eCL_LEN_1};
        auto_ack = 1'b1;
        start_req(42'h103, 6, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            checks++;
            if (mem_write_enable !== 1'b1 || mem_write_addr !== 42'h103 + 42'(i) ||
                mem_write_req_sop !== exp_sop[i] || mem_write_req_num_lines !== exp_len[i] ||
                mem_write_req_check_order !== 1'b1 || mem_write_req_cached !== 1'b0) begin
                errors++; $display("FAIL unaligned_beat[%0d]: en=%0b addr=%h sop=%0b len=%0d order=%0b expected 1/%h/%0b/%0d/1", i, mem_write_enable, mem_write_addr, mem_write_req_sop, mem_write_req_num_lines, mem_write_req_check_order, 42'h103 + 42'(i), exp_sop[i], exp_len[i]);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem_write_enable !== 1'b0 || burst_done !== 1'b1) begin
            errors++; $display("FAIL unaligned_done: en=%0b done=%0b expected 0/1", mem_write_enable, burst_done);
        end
        @(negedge clk);
        auto_ack = 1'b0;
    endtask

    task automatic test_backpressure();
        bit          rdy      [7] = '{1, 1, 0, 0, 0, 1, 1};
        bit          exp_sop  [7] = '{1, 0, 0, 0, 0, 0, 0};
        logic [41:0] exp_addr [7] = '{42'h200, 42'h201, 42'h202, 42'h202, 42'h202, 42'h202, 42'h203};
        auto_ack = 1'b1;
        start_req(42'h200, 4, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            req_valid     = 1'b0;
            mem_write_rdy = rdy[i];
            #1;
            checks++;
            if (mem_write_enable !== rdy[i] || wr_data_rdy !== rdy[i]) begin
                errors++; $display("FAIL bp_enable[%0d]: en=%0b wr_rdy=%0b expected %0b", i, mem_write_enable, wr_data_rdy, rdy[i]);
            end
            checks++;
            if (mem_write_addr !== exp_addr[i] || mem_write_req_sop !== exp_sop[i] ||
                mem_write_req_num_lines !== eCL_LEN_4) begin
                errors++; $display("FAIL bp_beat[%0d]: addr=%h sop=%0b len=%0d expected %h/%0b/3", i, mem_write_addr, mem_write_req_sop, mem_write_req_num_lines, exp_addr[i], exp_sop[i]);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (burst_done !== 1'b1 || mem_write_enable !== 1'b0) begin
            errors++; $display("FAIL bp_done: done=%0b en=%0b expected 1/0", burst_done, mem_write_enable);
        end
        @(negedge clk);
        auto_ack = 1'b0;
        #1;
        checks++;
        if (outstanding !== 3'd0 || idle !== 1'b1) begin
            errors++; $display("FAIL bp_drain: out=%0d idle=%0b expected 0/1", outstanding, idle);
        end
    endtask

    task automatic test_outstanding();
        logic [1:0]  ack     [12] = '{0, 0, 0, 0, 0, 2, 0, 0, 3, 0, 3, 0};
        bit          exp_en  [12] = '{1, 1, 1, 1, 0, 0, 1, 1, 0, 1, 1, 0};
        logic [2:0]  exp_out [12] = '{0, 1, 2, 3, 4, 4, 2, 3, 4, 1, 2, 0};
        bit          exp_sop [11] = '{1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        logic [41:0] exp_addr[11] = '{42'h300, 42'h301, 42'h302, 42'h303, 42'h304, 42'h304,
                                      42'h304, 42'h305, 42'h306, 42'h306, 42'h307};
        auto_ack = 1'b0; ack_man = 2'd0; mem_write_rdy = 1'b1; wr_data_valid = 1'b1;
        start_req(42'h300, 8, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            ack_man   = ack[i];
            #1;
            checks++;
            if (mem_write_enable !== exp_en[i] || outstanding !== exp_out[i]) begin
                errors++; $display("FAIL credit[%0d]: en=%0b out=%0d expected %0b/%0d", i, mem_write_enable, outstanding, exp_en[i], exp_out[i]);
            end
            if (i < 11) begin
                checks++;
                if (mem_write_addr !== exp_addr[i] || mem_write_req_sop !== exp_sop[i] ||
                    mem_write_req_num_lines !== eCL_LEN_4) begin
                    errors++; $display("FAIL credit_beat[%0d]: addr=%h sop=%0b len=%0d expected %h/%0b/3", i, mem_write_addr, mem_write_req_sop, mem_write_req_num_lines, exp_addr[i], exp_sop[i]);
                end
            end
        end
        checks++;
        if (burst_done !== 1'b1 || idle !== 1'b1) begin
            errors++; $display("FAIL credit_done: done=%0b idle=%0b expected 1/1", burst_done, idle);
        end
    endtask

    task automatic test_zero_lines();
        start_req(42'h500, 0, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (mem_write_enable !== 1'b0 || burst_done !== 1'b1 || idle !== 1'b1 || req_rdy !== 1'b1) begin
            errors++; $display("FAIL zero_done: en=%0b done=%0b idle=%0b rdy=%0b expected 0/1/1/1", mem_write_enable, burst_done, idle, req_rdy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (burst_done !== 1'b0 || idle !== 1'b1 || mem_write_enable !== 1'b0) begin
            errors++; $display("FAIL zero_after: done=%0b idle=%0b en=%0b expected 0/1/0", burst_done, idle, mem_write_enable);
        end
    endtask

    task automatic test_reset_mid_burst();
        auto_ack = 1'b0; ack_man = 2'd0;
        start_req(42'h400, 8, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            checks++;
            if (mem_write_enable !== 1'b1 || mem_write_addr !== 42'h400 + 42'(i)) begin
                errors++; $display("FAIL rst_pre[%0d]: en=%0b addr=%h expected 1/%h", i, mem_write_enable, mem_write_addr, 42'h400 + 42'(i));
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (mem_write_enable !== 1'b0 || wr_data_rdy !== 1'b0 || req_rdy !== 1'b0 || idle !== 1'b0) begin
            errors++; $display("FAIL rst_during: en=%0b wr_rdy=%0b rdy=%0b idle=%0b expected 0", mem_write_enable, wr_data_rdy, req_rdy, idle);
        end
        @(negedge clk);
        reset   = 1'b0;
        ack_man = 2'd2;
        #1;
        checks++;
        if (mem_write_enable !== 1'b0 || outstanding !== 3'd0 || req_rdy !== 1'b1 ||
            mem_write_req_sop !== 1'b0 || burst_done !== 1'b0) begin
            errors++; $display("FAIL rst_after: en=%0b out=%0d rdy=%0b sop=%0b done=%0b expected 0/0/1/0/0", mem_write_enable, outstanding, req_rdy, mem_write_req_sop, burst_done);
        end
        @(negedge clk);
        ack_man = 2'd0;
        #1;
        checks++;
        if (outstanding !== 3'd0 || idle !== 1'b1) begin
            errors++; $display("FAIL rst_late_ack: out=%0d idle=%0b expected 0/1", outstanding, idle);
        end
    endtask

    initial begin
        test_reset();
        test_aligned_burst();
        test_unaligned_burst();
        test_backpressure();
        test_outstanding();
        test_zero_lines();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
